serial_ule_comparator: RTL and testbench

SERIAL_ULE_COMPARATOR -- requirements
Module: serial_ule_comparator

---
 rtl/serial_ule_comparator.sv | 99 +++++++++
 tb/tb_serial_ule_comparator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ule_comparator.sv
// Bit-serial unsigned I0 <= I1 comparator, MSB first, valid/ready on both sides.
// Optional macro SERIAL_ULE_EARLY_EXIT_EN: finish on the first differing bit pair.
module serial_ule_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             O,
    output logic             eq
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             decided;
    logic             lt;

    logic a_bit;
    logic b_bit;
    logic first_diff;
    logic last;

    // Current bit pair and whether it is the deciding one
    always_comb begin
        a_bit      = a_q[idx];
        b_bit      = b_q[idx];
        first_diff = (a_bit != b_bit) && !decided;
        last       = (idx == '0);
    end

    // Handshake flags and result; result forced low outside DONE
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        O         = out_valid && (decided ? lt : 1'b1);
        eq        = out_valid && !decided;
    end

    // Control FSM plus operand and decision registers
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= I0;
                        b_q     <= I1;
                        decided <= 1'b0;
                        lt      <= 1'b0;
                        idx     <= IW'(WIDTH - 1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (first_diff) begin
                        lt      <= ~a_bit;
                        decided <= 1'b1;
                    end
`ifdef SERIAL_ULE_EARLY_EXIT_EN
                    if (last || first_diff)
                        state <= DONE;
                    else
                        idx <= idx - 1'b1;
`else
                    if (last)
                        state <= DONE;
                    else
                        idx <= idx - 1'b1;
`endif
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ule_comparator.sv
// Scoreboard bench for serial_ule_comparator (WIDTH=8).
// Expected results are queued on accept and checked on each result handshake.
module tb_serial_ule_comparator;

    logic       CLK;
    logic       RESETN;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] I0;
    logic [7:0] I1;
    logic       out_valid;
    logic       out_ready;
    logic       O;
    logic       eq;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    int res_cnt = 0;
    logic [1:0] exp_q[$];

    serial_ule_comparator #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I0        (I0),
        .I1        (I1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .O         (O),
        .eq        (eq)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
        int r;
        r = 8;
`ifdef SERIAL_ULE_EARLY_EXIT_EN
        for (int i = 0; i < 8; i++) begin
            if (r == 8 && a[7-i] != b[7-i])
                r = i + 1;
        end
`endif
        return r;
    endfunction

    // Accept side of scoreboard: reference model pushes expected result
    always @(negedge CLK) begin
        if (!RESETN) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back({(I0 <= I1), (I0 == I1)});
            acc_cnt++;
        end
    end

    // Result side of scoreboard plus idle-output check
    always @(negedge CLK) begin
        if (RESETN && out_valid && out_ready) begin
            total++;
            if (exp_q.size() != 1) begin
                bad++;
                $display("FAIL sb_depth: pending=%0d required=1", exp_q.size());
            end
            if (exp_q.size() > 0) begin
                logic [1:0] e;
                e = exp_q.pop_front();
                total++;
                if ({O, eq} !== e) begin
                    bad++;
                    $display("FAIL sb_result: {O,eq}=%b required=%b", {O, eq}, e);
                end
            end
            res_cnt++;
        end
        if (RESETN && !out_valid) begin
            total++;
            if ({O, eq} !== 2'b00) begin
                bad++;
                $display("FAIL idle_out: {O,eq}=%b required=00", {O, eq});
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_ready_timeout: in_ready=0 required=1", name);
        end
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input string name);
        int n;
        wait_ready(name);
        out_ready = 1'b1;
        I0 = a;
        I1 = b;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        I0 = ~a;
        I1 = ~b;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        total++;
        if (n != exp_lat(a, b)) begin
            bad++;
            $display("FAIL %s_latency: edges=%0d required=%0d", name, n, exp_lat(a, b));
        end
        total++;
        if (O !== (a <= b) || eq !== (a == b)) begin
            bad++;
            $display("FAIL %s_direct: O=%b eq=%b required O=%b eq=%b",
                     name, O, eq, (a <= b), (a == b));
        end
        @(posedge CLK); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_return: in_ready=%b out_valid=%b required 1 0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        RESETN = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        I0 = 8'h00;
        I1 = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({in_ready, out_valid, O, eq} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_state: rdy,vld,O,eq=%b required=1000",
                     {in_ready, out_valid, O, eq});
        end
        RESETN = 1'b1;
    endtask

    task automatic test_directed;
        run_one(8'h3C, 8'h3C, "equal");
        run_one(8'h80, 8'h7F, "msb_diff");
        run_one(8'h12, 8'h13, "lsb_diff");
        run_one(8'h00, 8'hFF, "zero_max");
        run_one(8'hFF, 8'h00, "max_zero");
    endtask

    task automatic test_back_to_back;
        run_one(8'h5A, 8'h5B, "b2b_a");
        run_one(8'h5B, 8'h5A, "b2b_b");
        run_one(8'hFF, 8'hFF, "b2b_c");
    endtask

    task automatic test_backpressure;
        int n;
        logic o_s;
        logic e_s;
        wait_ready("bp");
        out_ready = 1'b0;
        I0 = 8'h12;
        I1 = 8'h13;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        o_s = O;
        e_s = eq;
        total++;
        if (out_valid !== 1'b1 || o_s !== 1'b1 || e_s !== 1'b0) begin
            bad++;
            $display("FAIL bp_first: vld=%b O=%b eq=%b required 1 1 0", out_valid, o_s, e_s);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1);
            I0 = 8'hFF;
            I1 = 8'h00;
            @(posedge CLK); #1;
            total++;
            if (out_valid !== 1'b1 || O !== o_s || eq !== e_s || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: vld=%b O=%b eq=%b rdy=%b required 1 %b %b 0",
                         i, out_valid, O, eq, in_ready, o_s, e_s);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (in_ready !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_ignored: rdy=%b pending=%0d required 1 0", in_ready, exp_q.size());
        end
    endtask

    task automatic test_mid_reset;
        logic seen;
        wait_ready("rst");
        out_ready = 1'b1;
        I0 = 8'hA5;
        I1 = 8'hA5;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_pre: vld=%b rdy=%b required 0 0", out_valid, in_ready);
        end
        RESETN = 1'b0;
        @(posedge CLK); #1;
        total++;
        if ({in_ready, out_valid, O, eq} !== 4'b1000) begin
            bad++;
            $display("FAIL rst_mid: rdy,vld,O,eq=%b required=1000",
                     {in_ready, out_valid, O, eq});
        end
        RESETN = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (out_valid)
                seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rst_stale: out_valid seen=%b required=0", seen);
        end
    endtask

    task automatic test_random;
        int acc0;
        int res0;
        int n;
        wait_ready("rnd");
        acc0 = acc_cnt;
        res0 = res_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while ((acc_cnt - acc0) < 1000 && n < 15000) begin
            I0 = 8'($urandom);
            I1 = 8'($urandom);
            @(posedge CLK); #1;
            n++;
        end
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        total++;
        if ((acc_cnt - acc0) != 1000 || (res_cnt - res0) != 1000) begin
            bad++;
            $display("FAIL rnd_count: accepts=%0d results=%0d required 1000 1000",
                     acc_cnt - acc0, res_cnt - res0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
